mips_harvard_avalon_bridge: RTL and testbench
=============================================

Name: mips_harvard_avalon_bridge

Overview:
- Sits between the Harvard CPU core and a single shared Avalon-MM memory bus.
- Serves the core's combinational instruction and data ports from one wait-stated bus: per instruction step it fetches the instruction word, performs at most one data access, then pulses the core's clk_enable for one cycle.
- Returned words are buffered in registers so the core sees stable combinational data while it is stalled.

Parameters:
- ADDR_W, 32, width of avm_address
- TIMEOUT_CYCLES, 1024, waitrequest cycles tolerated per bus access (used only with BRIDGE_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_active  in  1  core active flag; low = core halted
- cpu_clk_enable  out  1  single-cycle step pulse to core
- cpu_instr_address  in  32  core fetch address
- cpu_instr_readdata  out  32  buffered instruction word
- cpu_data_address  in  32  core data address
- cpu_data_read  in  1  core data read request
- cpu_data_write  in  1  core data write request
- cpu_data_byteenable  in  4  core byte lanes
- cpu_data_writedata  in  32  core store data
- cpu_data_readdata  out  32  buffered load data
- avm_address  out  ADDR_W  bus address, bits [1:0] always 0
- avm_read  out  1  bus read
- avm_write  out  1  bus write
- avm_byteenable  out  4  bus byte lanes
- avm_writedata  out  32  bus write data
- avm_readdata  in  32  bus read data
- avm_waitrequest  in  1  slave stall
- bus_error  out  1  sticky timeout flag (BRIDGE_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset values: state=FETCH, cpu_clk_enable=0, avm_read=0, avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0, cpu_instr_readdata=0, cpu_data_readdata=0, bus_error=0.
- Reset mid-transaction aborts immediately. Bus strobes are low the cycle after the reset edge. No completion is reported to the core.
- States: FETCH, DATA, STEP, HALT, ERROR.
- FETCH
  - avm_read=1, avm_address={cpu_instr_address[31:2],2'b00}, avm_byteenable=4'hF.
  - On a cycle with waitrequest=0: latch avm_readdata into cpu_instr_readdata and drop avm_read the next cycle.
  - Go to DATA if cpu_data_read|cpu_data_write, else STEP.
- DATA
  - Write: avm_write=1 with address, byteenable and writedata copied from the core.
  - Read: avm_read=1 with core byteenable. On completion latch avm_readdata into cpu_data_readdata.
  - Read and write both high: write only, cpu_data_readdata unchanged.
  - Completion goes to STEP.
- Bus rule: address, byteenable, writedata and strobes are held constant while waitrequest=1. Completion is the cycle with strobe=1 and waitrequest=0. Strobes never stay high for two completed beats.
- STEP
  - cpu_clk_enable=1 for exactly one cycle, no bus activity.
  - Next state is FETCH if cpu_active=1, else HALT.
- Core inputs are sampled only while strobes are asserted. The core is stalled throughout, so they are stable.
- HALT: no bus activity, cpu_clk_enable=0. Left only by reset.
- Latency with zero wait states: 2 cycles per non-memory instruction, 3 per load/store. Each waitrequest cycle adds 1.
- cpu_instr_readdata and cpu_data_readdata change only on bus completion. They are stable throughout STEP.
- Entry check in FETCH: if cpu_active=0 on entry, go to HALT without issuing a read.

Optional Feature:
- Macro: BRIDGE_TIMEOUT_EN.
- Defined:
  - A per-access counter clears on strobe assertion and increments on each waitrequest=1 cycle.
  - When it reaches TIMEOUT_CYCLES: drop strobes, set bus_error=1 (sticky until reset), enter ERROR.
  - ERROR: no bus activity, cpu_clk_enable=0.
- Undefined: no counter, bus_error tied 0, ERROR unreachable, bridge waits indefinitely.

Test Plan:
- Reset release, instruction memory at 0xBFC00000 = 0x24020005, waitrequest=0: avm_read at 0xBFC00000 in cycle 1; cpu_instr_readdata=0x24020005 and cpu_clk_enable pulse in cycle 2; no DATA access.
- Core requests LW at 0x00001004 with memory word 0xDEADBEEF and waitrequest high for 3 cycles: address and strobe stable for 4 cycles; cpu_data_readdata=0xDEADBEEF; STEP 1 cycle later.
- SB with cpu_data_byteenable=4'b0100 and writedata 0x00AB0000 at 0x00002002: avm_write at 0x00002000, byteenable 4'b0100, writedata 0x00AB0000, exactly one beat.
- cpu_active falls during a step: next state after STEP is HALT; zero avm_read/avm_write for 100 cycles; cpu_clk_enable stays 0.
- Reset asserted during FETCH with waitrequest=1: avm_read=0 on the next cycle; after release, a fresh fetch at the new cpu_instr_address.
- BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, waitrequest stuck at 1: avm_read drops after 8 stall cycles, bus_error=1 and held, cpu_clk_enable never pulses.

Source files
------------

// File: rtl/mips_harvard_avalon_bridge.sv
// mips_harvard_avalon_bridge
//
// Connects a Harvard CPU core to one shared Avalon-MM bus. The core has a
// combinational instruction port and a combinational data port. For each
// instruction step the bridge does three things:
//   1. fetches the instruction word
//   2. performs at most one data access
//   3. pulses cpu_clk_enable for one cycle
// Returned words are held in registers, so the core sees stable data while
// it is stalled.
//
// Bus strobes are decoded from the FSM state. Address, byteenable and
// writedata are routed straight from the core inputs while a strobe is up.
// The core is stalled for the whole access, so these values stay constant
// across waitrequest cycles.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cpu_active            core running flag (low = halted)
//   cpu_clk_enable        one-cycle step pulse to the core
//   cpu_instr_address     core fetch address
//   cpu_instr_readdata    buffered instruction word
//   cpu_data_*            core data request (address/read/write/byteenable/writedata)
//   cpu_data_readdata     buffered load data
//   avm_*                 Avalon-MM master port (word-aligned address)
//   bus_error             sticky timeout flag
//
// Optional feature (macro BRIDGE_TIMEOUT_EN):
//   Each bus access may stall for at most TIMEOUT_CYCLES waitrequest cycles.
//   When that limit is reached the bridge drops the strobe, sets bus_error
//   and parks in ERROR.
//   Without the macro, bus_error is tied to 0 and the bridge waits
//   indefinitely.

module mips_harvard_avalon_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_active,
    output logic              cpu_clk_enable,
    input  logic [31:0]       cpu_instr_address,
    output logic [31:0]       cpu_instr_readdata,
    input  logic [31:0]       cpu_data_address,
    input  logic              cpu_data_read,
    input  logic              cpu_data_write,
    input  logic [3:0]        cpu_data_byteenable,
    input  logic [31:0]       cpu_data_writedata,
    output logic [31:0]       cpu_data_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              bus_error
);

    typedef enum logic [2:0] {
        FETCH,
        DATA,
        STEP,
        HALT,
        ERROR
    } state_t;

    state_t      state, state_next;

    // fetch_go is low on the first FETCH cycle after reset. That cycle
    // performs the cpu_active entry check without touching the bus.
    // STEP re-enters FETCH with fetch_go already set, because STEP has
    // already checked cpu_active.
    logic        fetch_go, fetch_go_next;
    logic [31:0] addr_word;
    logic        strobe;
    logic        complete;

    assign strobe   = avm_read | avm_write;
    assign complete = strobe & ~avm_waitrequest;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             bus_error_r;

    assign timeout_hit = strobe & avm_waitrequest &
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error   = bus_error_r;

    // Counts stall cycles of the current access. It is held at zero
    // whenever no access is pending, and is cleared on completion so that
    // the FETCH->DATA back-to-back beats start fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            bus_error_r <= 1'b0;
        end else begin
            if (strobe && avm_waitrequest)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit)
                bus_error_r <= 1'b1;
        end
    end
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= FETCH;
            fetch_go           <= 1'b0;
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
        end else begin
            state    <= state_next;
            fetch_go <= fetch_go_next;
            // Buffers change only on a completed read beat.
            if (avm_read && !avm_waitrequest) begin
                if (state == FETCH)
                    cpu_instr_readdata <= avm_readdata;
                else
                    cpu_data_readdata <= avm_readdata;
            end
        end
    end

    always_comb begin
        state_next     = state;
        fetch_go_next  = fetch_go;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_byteenable = 4'h0;
        avm_writedata  = 32'h0;
        addr_word      = 32'h0;
        cpu_clk_enable = 1'b0;

        case (state)
            FETCH: begin
                if (!fetch_go) begin
                    if (!cpu_active)
                        state_next = HALT;
                    else
                        fetch_go_next = 1'b1;
                end else begin
                    avm_read       = 1'b1;
                    addr_word      = cpu_instr_address & 32'hFFFF_FFFC;
                    avm_byteenable = 4'hF;
                    if (!avm_waitrequest) begin
                        fetch_go_next = 1'b0;
                        state_next    = (cpu_data_read | cpu_data_write) ? DATA : STEP;
                    end
                end
            end

            DATA: begin
                addr_word      = cpu_data_address & 32'hFFFF_FFFC;
                avm_byteenable = cpu_data_byteenable;
                // A write takes priority when both requests are raised.
                if (cpu_data_write) begin
                    avm_write     = 1'b1;
                    avm_writedata = cpu_data_writedata;
                end else begin
                    avm_read = 1'b1;
                end
                if (!avm_waitrequest)
                    state_next = STEP;
            end

            STEP: begin
                cpu_clk_enable = 1'b1;
                if (cpu_active) begin
                    state_next    = FETCH;
                    fetch_go_next = 1'b1;
                end else begin
                    state_next = HALT;
                end
            end

            HALT:  state_next = HALT;
            ERROR: state_next = ERROR;
            default: state_next = FETCH;
        endcase

`ifdef BRIDGE_TIMEOUT_EN
        if (timeout_hit) begin
            state_next    = ERROR;
            fetch_go_next = 1'b0;
        end
`endif
    end

    assign avm_address = ADDR_W'(addr_word);

    // Completion is decoded for readability of the bus handshake; the
    // registers above use the same term explicitly per strobe.
    logic unused_complete;
    assign unused_complete = complete;

endmodule

// File: tb/tb_mips_harvard_avalon_bridge.sv
// Directed testbench for mips_harvard_avalon_bridge.
// Memory is a combinational model keyed on the bus address. waitrequest is
// driven step by step. Outputs are sampled on the falling edge, and inputs
// are changed on the same falling edge.

module tb_mips_harvard_avalon_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] cpu_instr_address;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [3:0]  cpu_data_byteenable;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        bus_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_harvard_avalon_bridge #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_active(cpu_active),
        .cpu_clk_enable(cpu_clk_enable),
        .cpu_instr_address(cpu_instr_address),
        .cpu_instr_readdata(cpu_instr_readdata),
        .cpu_data_address(cpu_data_address),
        .cpu_data_read(cpu_data_read),
        .cpu_data_write(cpu_data_write),
        .cpu_data_byteenable(cpu_data_byteenable),
        .cpu_data_writedata(cpu_data_writedata),
        .cpu_data_readdata(cpu_data_readdata),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .bus_error(bus_error)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: mem_word = 32'h2402_0005;
            32'hBFC0_0004: mem_word = 32'h8C02_1004;
            32'h0000_1004: mem_word = 32'hDEAD_BEEF;
            default:       mem_word = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    assign avm_readdata = mem_word(avm_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    initial begin
        int busy;

        reset               = 1'b1;
        cpu_active          = 1'b1;
        cpu_instr_address   = 32'hBFC0_0000;
        cpu_data_address    = 32'h0;
        cpu_data_read       = 1'b0;
        cpu_data_write      = 1'b0;
        cpu_data_byteenable = 4'h0;
        cpu_data_writedata  = 32'h0;
        avm_waitrequest     = 1'b0;
        repeat (2) ne();

        chk("rst_read",     avm_read, 0);
        chk("rst_write",    avm_write, 0);
        chk("rst_clken",    cpu_clk_enable, 0);
        chk("rst_addr",     avm_address, 0);
        chk("rst_be",       avm_byteenable, 0);
        chk("rst_wd",       avm_writedata, 0);
        chk("rst_instr",    cpu_instr_readdata, 0);
        chk("rst_data",     cpu_data_readdata, 0);
        chk("rst_buserr",   bus_error, 0);

        // Boot fetch, zero wait states
        reset = 1'b0;
        ne();
        chk("f0_read",  avm_read, 1);
        chk("f0_addr",  avm_address, 32'hBFC0_0000);
        chk("f0_be",    avm_byteenable, 4'hF);
        chk("f0_clken", cpu_clk_enable, 0);
        ne();
        chk("s0_clken", cpu_clk_enable, 1);
        chk("s0_instr", cpu_instr_readdata, 32'h2402_0005);
        chk("s0_read",  avm_read, 0);
        chk("s0_write", avm_write, 0);

        // LW 0x1004 with three stall cycles
        cpu_instr_address   = 32'hBFC0_0004;
        cpu_data_address    = 32'h0000_1004;
        cpu_data_read       = 1'b1;
        cpu_data_byteenable = 4'hF;
        ne();
        chk("f1_read",  avm_read, 1);
        chk("f1_addr",  avm_address, 32'hBFC0_0004);
        ne();
        chk("lw_read",  avm_read, 1);
        chk("lw_addr",  avm_address, 32'h0000_1004);
        chk("lw_be",    avm_byteenable, 4'hF);
        chk("lw_clken", cpu_clk_enable, 0);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ne();
            chk("lw_hold_read", avm_read, 1);
            chk("lw_hold_addr", avm_address, 32'h0000_1004);
            chk("lw_hold_data", cpu_data_readdata, 0);
        end
        avm_waitrequest = 1'b0;
        ne();
        chk("lw_step_clken", cpu_clk_enable, 1);
        chk("lw_step_data",  cpu_data_readdata, 32'hDEAD_BEEF);
        chk("lw_step_read",  avm_read, 0);

        // SB at 0x2002, byte lane 2
        cpu_instr_address   = 32'hBFC0_0008;
        cpu_data_read       = 1'b0;
        cpu_data_write      = 1'b1;
        cpu_data_address    = 32'h0000_2002;
        cpu_data_byteenable = 4'b0100;
        cpu_data_writedata  = 32'h00AB_0000;
        ne();
        chk("f2_read",  avm_read, 1);
        chk("f2_write", avm_write, 0);
        chk("f2_addr",  avm_address, 32'hBFC0_0008);
        ne();
        chk("sb_write", avm_write, 1);
        chk("sb_read",  avm_read, 0);
        chk("sb_addr",  avm_address, 32'h0000_2000);
        chk("sb_be",    avm_byteenable, 4'b0100);
        chk("sb_wd",    avm_writedata, 32'h00AB_0000);
        ne();
        chk("sb_one_beat", avm_write, 0);
        chk("sb_clken",    cpu_clk_enable, 1);
        chk("sb_data_kept", cpu_data_readdata, 32'hDEAD_BEEF);

        // Non-memory instruction; core goes inactive during its step
        cpu_data_write    = 1'b0;
        cpu_instr_address = 32'hBFC0_000C;
        ne();
        chk("f3_read", avm_read, 1);
        ne();
        chk("s3_clken", cpu_clk_enable, 1);
        chk("s3_instr", cpu_instr_readdata, 32'h1A65_A5A9);
        cpu_active = 1'b0;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            ne();
            if (avm_read || avm_write || cpu_clk_enable)
                busy++;
        end
        chk("halt_quiet", busy, 0);
        chk("halt_buserr", bus_error, 0);

        // Reset while a fetch is stalled
        reset             = 1'b1;
        cpu_active        = 1'b1;
        cpu_instr_address = 32'hBFC0_0000;
        avm_waitrequest   = 1'b1;
        ne();
        reset = 1'b0;
        ne();
        chk("rf_read",  avm_read, 1);
        chk("rf_addr",  avm_address, 32'hBFC0_0000);
        ne();
        chk("rf_stall", avm_read, 1);
        reset             = 1'b1;
        cpu_instr_address = 32'h0040_0000;
        ne();
        chk("rf_abort_read",  avm_read, 0);
        chk("rf_abort_addr",  avm_address, 0);
        chk("rf_abort_instr", cpu_instr_readdata, 0);
        chk("rf_abort_clken", cpu_clk_enable, 0);
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        ne();
        chk("rf_new_read", avm_read, 1);
        chk("rf_new_addr", avm_address, 32'h0040_0000);
        ne();
        chk("rf_new_clken", cpu_clk_enable, 1);
        chk("rf_new_instr", cpu_instr_readdata, 32'hA5E5_A5A5);

`ifdef BRIDGE_TIMEOUT_EN
        // Stuck slave: the read must drop after 8 stall cycles
        reset           = 1'b1;
        avm_waitrequest = 1'b1;
        ne();
        reset = 1'b0;
        ne();
        for (int i = 0; i < 8; i++) begin
            chk("to_read_held", avm_read, 1);
            chk("to_no_err",    bus_error, 0);
            ne();
        end
        chk("to_read_drop", avm_read, 0);
        chk("to_buserr",    bus_error, 1);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            ne();
            if (avm_read || avm_write || cpu_clk_enable)
                busy++;
        end
        chk("to_quiet",      busy, 0);
        chk("to_buserr_held", bus_error, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
